// File: rtl/core_scoreboard.sv
// Issue-side register scoreboard: tracks outstanding register writes, gates issue on hazards, drain handshake.
// Optional macro CORE_SB_WB_BYPASS_EN lets a same-cycle writeback release hazards for issue.
module core_scoreboard #(
    parameter int NUM_REGS        = 32,
    parameter int MAX_PEND        = 3,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                                 clk_i,
    input  logic                                 arst_ni,
    input  logic                                 issue_valid_i,
    output logic                                 issue_ready_o,
    input  logic [4:0]                           rs1_addr_i,
    input  logic [4:0]                           rs2_addr_i,
    input  logic [4:0]                           rd_addr_i,
    input  logic                                 rs1_used_i,
    input  logic                                 rs2_used_i,
    input  logic                                 rd_wr_i,
    input  logic                                 wb_valid_i,
    input  logic [4:0]                           wb_rd_addr_i,
    input  logic                                 flush_i,
    input  logic                                 drain_i,
    output logic                                 drain_done_o,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
    output logic                                 busy_o
);

    localparam int CW = $clog2(MAX_PEND + 1);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0] PEND_MAX = CW'(MAX_PEND);
    localparam logic [OW-1:0] OUT_MAX  = OW'(MAX_OUTSTANDING);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {RUN, DRAIN, DRAINED} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q [NUM_REGS];
    logic [OW-1:0] outstanding_q;

    logic [CW-1:0] cnt_rs1, cnt_rs2, cnt_rd, cnt_wb;
    logic          issue_wr, wb_retire, fire_wr;
    logic          rs1_release, rs2_release, rd_release, full_release;
    logic          raw, waw, full;

    assign cnt_rs1 = cnt_q[rs1_addr_i];
    assign cnt_rs2 = cnt_q[rs2_addr_i];
    assign cnt_rd  = cnt_q[rd_addr_i];
    assign cnt_wb  = cnt_q[wb_rd_addr_i];

    assign issue_wr  = rd_wr_i & (rd_addr_i != 5'd0);
    // A writeback to an idle register (possible after a flush) retires nothing.
    assign wb_retire = wb_valid_i & (wb_rd_addr_i != 5'd0) & (cnt_wb != '0);

`ifdef CORE_SB_WB_BYPASS_EN
    assign rs1_release  = wb_retire & (wb_rd_addr_i == rs1_addr_i) & (cnt_rs1 == CNT_ONE);
    assign rs2_release  = wb_retire & (wb_rd_addr_i == rs2_addr_i) & (cnt_rs2 == CNT_ONE);
    assign rd_release   = wb_retire & (wb_rd_addr_i == rd_addr_i);
    assign full_release = wb_retire;
`else
    assign rs1_release  = 1'b0;
    assign rs2_release  = 1'b0;
    assign rd_release   = 1'b0;
    assign full_release = 1'b0;
`endif

    assign raw  = (rs1_used_i & (rs1_addr_i != 5'd0) & (cnt_rs1 != '0) & ~rs1_release)
                | (rs2_used_i & (rs2_addr_i != 5'd0) & (cnt_rs2 != '0) & ~rs2_release);
    assign waw  = issue_wr & (cnt_rd == PEND_MAX) & ~rd_release;
    assign full = (outstanding_q == OUT_MAX) & ~full_release;

    assign issue_ready_o = arst_ni & (state_q == RUN) & ~flush_i & ~raw & ~waw & ~(full & issue_wr);
    assign fire_wr       = issue_valid_i & issue_ready_o & issue_wr;

    // Same-register issue and retire in one cycle cancel out.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            for (int i = 0; i < NUM_REGS; i++) cnt_q[i] <= '0;
        end else if (flush_i) begin
            for (int i = 0; i < NUM_REGS; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (fire_wr && (rd_addr_i == 5'(i)) && !(wb_retire && (wb_rd_addr_i == 5'(i))))
                    cnt_q[i] <= cnt_q[i] + CNT_ONE;
                else if (wb_retire && (wb_rd_addr_i == 5'(i)) && !(fire_wr && (rd_addr_i == 5'(i))))
                    cnt_q[i] <= cnt_q[i] - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            outstanding_q <= '0;
        end else if (flush_i) begin
            outstanding_q <= '0;
        end else if (fire_wr && !wb_retire) begin
            outstanding_q <= outstanding_q + OW'(1);
        end else if (wb_retire && !fire_wr) begin
            outstanding_q <= outstanding_q - OW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) state_q <= RUN;
        else          state_q <= state_d;
    end

    // Dropping drain_i aborts the handshake from any state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (drain_i) state_d = DRAIN;
            DRAIN:   if (!drain_i) state_d = RUN;
                     else if (outstanding_q == '0) state_d = DRAINED;
            DRAINED: if (!drain_i) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    assign drain_done_o  = (state_q == DRAINED);
    assign outstanding_o = outstanding_q;
    assign busy_o        = (outstanding_q != '0);

endmodule
